alu_lp_scheduler: RTL and testbench

Shares one alu_16bit_low_power instance between NUM_REQ requesters using valid/ready requests and a shared response channel.
Owns the ALU enable (clock-gate) signal: wakes the ALU on demand, keeps it open across back-to-back work, and gates it after an idle timeout.
Holds ALU operands at zero while gated (operand isolation).
Sits between the requesting datapath blocks and the ALU.

---
 rtl/alu_lp_pkg.sv | 21 ++
 rtl/alu_lp_rr_arbiter.sv | 48 ++++
 rtl/alu_lp_scheduler.sv | 175 +++++++++++++++++
 tb/tb_alu_lp_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_lp_pkg.sv
// Shared definitions for the low-power ALU scheduler: opcodes, widths, FSM states.
package alu_lp_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int OP_W      = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [2:0] {
    SLEEP = 3'd0,
    WAKE  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4,
    HOLD  = 3'd5
  } state_t;

endpackage

// File: rtl/alu_lp_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at the pointer with wrap,
// pointer advances past the winner whenever the owner strobes grant_en.
module alu_lp_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       grant_en,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int             IDW     = $clog2(NUM_REQ);
  localparam int             IDW1    = IDW + 1;
  localparam logic [IDW:0]   NUM_W   = IDW1'(NUM_REQ);
  localparam logic [IDW-1:0] LAST    = IDW'(NUM_REQ - 1);
  localparam logic [IDW-1:0] ONE_IDX = IDW'(1);

  logic [IDW-1:0] ptr_r;

  // Pick the first valid request at or after the pointer; scanning downward lets the nearest win
  always_comb begin
    logic [IDW:0]   sum_s;
    logic [IDW-1:0] cand_s;
    grant_valid = |req;
    grant_idx   = '0;
    sum_s       = '0;
    cand_s      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum_s     = {1'b0, ptr_r} + IDW1'(i);
      cand_s    = (sum_s >= NUM_W) ? IDW'(sum_s - NUM_W) : IDW'(sum_s);
      grant_idx = req[cand_s] ? cand_s : grant_idx;
    end
  end

  // Advance the pointer one past the granted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (grant_en) begin
      ptr_r <= (grant_idx == LAST) ? '0 : grant_idx + ONE_IDX;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/alu_lp_scheduler.sv
// Shares one low-power ALU among NUM_REQ requesters. Owns the ALU clock-gate
// enable: wakes on demand, stays open across back-to-back work, gates after an
// idle timeout, and isolates (zeroes) the ALU operands whenever no op is live.
module alu_lp_scheduler
  import alu_lp_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int WIDTH        = ALU_WIDTH,
  parameter int ALU_LAT      = 1,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*OP_W-1:0]    req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_zero,
  output logic                       rsp_carry,
  output logic                       alu_enable,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [OP_W-1:0]            alu_op,
  input  logic [WIDTH-1:0]           alu_result,
  input  logic                       alu_zero,
  input  logic                       alu_carry,
  output logic                       busy
);

  localparam int               IDW       = $clog2(NUM_REQ);
  localparam logic [2:0]       LAT_INIT  = 3'(ALU_LAT - 1);
  localparam logic [7:0]       IDLE_INIT = 8'(IDLE_TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t         state_r;
  state_t         state_n;
  logic           grant_en_s;
  logic           grant_valid_s;
  logic [IDW-1:0] grant_idx_s;
  logic [2:0]     lat_cnt_r;
  logic [7:0]     idle_cnt_r;

  alu_lp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req_valid),
    .grant_en    (grant_en_s),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= SLEEP;
    else        state_r <= state_n;
  end

  // Next-state logic; grant_en_s marks every edge that moves into ISSUE
  always_comb begin
    state_n    = state_r;
    grant_en_s = 1'b0;
    case (state_r)
      SLEEP: begin
        if (grant_valid_s) state_n = WAKE;
        else               state_n = SLEEP;
      end
      WAKE: begin
        if (grant_valid_s) begin
          state_n    = ISSUE;
          grant_en_s = 1'b1;
        end else begin
          state_n = HOLD;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (lat_cnt_r == 3'd0) state_n = RESP;
        else                   state_n = WAIT;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          if (grant_valid_s) begin
            state_n    = ISSUE;
            grant_en_s = 1'b1;
          end else begin
            state_n = HOLD;
          end
        end else begin
          state_n = RESP;
        end
      end
      HOLD: begin
        // a request on the expiry cycle still wins over gating
        if (grant_valid_s) begin
          state_n    = ISSUE;
          grant_en_s = 1'b1;
        end else if (idle_cnt_r <= 8'd1) begin
          state_n = SLEEP;
        end else begin
          state_n = HOLD;
        end
      end
      default: state_n = SLEEP;
    endcase
  end

  // Registered outputs: grant/capture, operand isolation, response and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
      alu_enable <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      busy       <= 1'b0;
      lat_cnt_r  <= 3'd0;
      idle_cnt_r <= 8'd0;
    end else begin
      alu_enable <= (state_n != SLEEP);
      busy       <= (state_n != SLEEP);
      req_ready  <= '0;

      if (grant_en_s) begin
        req_ready <= ONE_HOT0 << grant_idx_s;
        alu_a     <= req_a[grant_idx_s*WIDTH +: WIDTH];
        alu_b     <= req_b[grant_idx_s*WIDTH +: WIDTH];
        alu_op    <= req_op[grant_idx_s*OP_W +: OP_W];
        rsp_id    <= grant_idx_s;
        lat_cnt_r <= LAT_INIT;
      end else if (state_n == HOLD || state_n == SLEEP || state_n == WAKE) begin
        alu_a  <= '0;
        alu_b  <= '0;
        alu_op <= '0;
      end else begin
        alu_a  <= alu_a;
        alu_b  <= alu_b;
        alu_op <= alu_op;
      end

      if (state_r == WAIT) begin
        if (lat_cnt_r == 3'd0) begin
          rsp_data  <= alu_result;
          rsp_zero  <= alu_zero;
          rsp_carry <= alu_carry;
          rsp_valid <= 1'b1;
        end else begin
          lat_cnt_r <= lat_cnt_r - 3'd1;
        end
      end else if (state_r == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end else begin
        rsp_valid <= rsp_valid;
      end

      if (state_n == HOLD && state_r != HOLD) begin
        idle_cnt_r <= IDLE_INIT;
      end else if (state_r == HOLD) begin
        idle_cnt_r <= idle_cnt_r - 8'd1;
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_alu_lp_scheduler.sv
// Self-checking bench for alu_lp_scheduler with a behavioural 1-cycle ALU and a
// response scoreboard fed by the stimulus.
module tb_alu_lp_scheduler;
  import alu_lp_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int W       = 16;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*W-1:0]       req_a = '0;
  logic [NUM_REQ*W-1:0]       req_b = '0;
  logic [NUM_REQ*3-1:0]       req_op = '0;
  logic                       rsp_valid;
  logic                       rsp_ready = 1'b1;
  logic [$clog2(NUM_REQ)-1:0] rsp_id;
  logic [W-1:0]               rsp_data;
  logic                       rsp_zero;
  logic                       rsp_carry;
  logic                       alu_enable;
  logic [W-1:0]               alu_a;
  logic [W-1:0]               alu_b;
  logic [2:0]                 alu_op;
  logic [W-1:0]               alu_result;
  logic                       alu_zero;
  logic                       alu_carry;
  logic                       busy;

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        zero;
    logic        carry;
  } exp_t;

  exp_t               sb[$];
  int                 vectors = 0;
  int                 miscompares = 0;
  int                 cyc = 0;
  logic [NUM_REQ-1:0] rdy_s = '0;

  alu_lp_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(W), .ALU_LAT(1), .IDLE_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .alu_enable(alu_enable), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle counter, steps on every active edge
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: {carry, zero, result}; carry is carry-out for ADD, borrow for SUB
  function automatic logic [17:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    logic [16:0] t;
    logic [31:0] m;
    m = 32'd0;
    case (op)
      OP_ADD:  t = {1'b0, a} + {1'b0, b};
      OP_SUB:  t = {1'b0, a} - {1'b0, b};
      OP_AND:  t = {1'b0, a & b};
      OP_MUL:  begin m = a * b; t = {1'b0, m[15:0]}; end
      default: t = 17'd0;
    endcase
    return {t[16], (t[15:0] == 16'd0), t[15:0]};
  endfunction

  // ALU stand-in: one cycle from stable operands to result, frozen while gated
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) {alu_carry, alu_zero, alu_result} <= 18'd0;
    else if (alu_enable) {alu_carry, alu_zero, alu_result} <= alu_model(alu_a, alu_b, alu_op);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard on each handshake, also checks grant one-hotness
  always @(negedge clk) begin
    exp_t e;
    rdy_s = req_ready;
    if (rst_n) begin
      check_val("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
      if (rsp_valid && rsp_ready) begin
        check_val("rsp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_val("rsp_id", 64'(rsp_id), 64'(e.id));
          check_val("rsp_data", 64'(rsp_data), 64'(e.data));
          check_val("rsp_zero", 64'(rsp_zero), 64'(e.zero));
          check_val("rsp_carry", 64'(rsp_carry), 64'(e.carry));
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_proto
    a_hold_valid: assert property (@(posedge clk) disable iff (!rst_n)
                                   (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi])
      else $error("requester %0d dropped req_valid before req_ready", gi);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (vectors %0d)", vectors);
    $fatal(1, "watchdog");
  end

  // Advance to just after the next active edge, retiring requests granted last cycle
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~rdy_s;
  endtask

  task automatic raise(input int r, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_op[r*3 +: 3] = op;
    req_valid[r] = 1'b1;
  endtask

  task automatic expect_rsp(input int id, input logic [15:0] d, input logic z, input logic c);
    exp_t e;
    e.id = id; e.data = d; e.zero = z; e.carry = c;
    sb.push_back(e);
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check_val("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ctl"}, 64'({req_ready, rsp_valid, rsp_id, rsp_zero, rsp_carry, alu_enable, alu_op, busy}), 64'd0);
    check_val({tag, "_data"}, 64'({rsp_data, alu_a, alu_b}), 64'd0);
  endtask

  // Request from SLEEP: grant at cycle 2, response at cycle 4, then 4 idle HOLD cycles and gate
  task automatic scen_wake(input logic [15:0] a, input logic [15:0] b, input logic [15:0] d);
    logic [15:0] ea;
    logic [15:0] eb;
    logic        een;
    expect_rsp(0, d, (d == 16'd0), 1'b0);
    raise(0, a, b, OP_ADD);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      een = (n >= 1 && n <= 8);
      ea  = (n >= 2 && n <= 4) ? a : 16'd0;
      eb  = (n >= 2 && n <= 4) ? b : 16'd0;
      check_val($sformatf("wake_ready_c%0d", n), 64'(req_ready), (n == 2) ? 64'd1 : 64'd0);
      check_val($sformatf("wake_en_c%0d", n), 64'(alu_enable), 64'(een));
      check_val($sformatf("wake_busy_c%0d", n), 64'(busy), 64'(een));
      check_val($sformatf("wake_rspv_c%0d", n), 64'(rsp_valid), (n == 4) ? 64'd1 : 64'd0);
      check_val($sformatf("wake_alu_ab_c%0d", n), 64'({alu_a, alu_b}), 64'({ea, eb}));
      check_val($sformatf("wake_alu_op_c%0d", n), 64'(alu_op), 64'd0);
      tick();
      if (n >= 4) begin
        req_a  = $urandom();
        req_b  = $urandom();
        req_op = 6'($urandom());
      end
    end
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs;
    int g;
    // reset state
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single ADD from sleep, then idle gating with toggling payloads
    scen_wake(16'd1000, 16'd500, 16'd1500);

    // contention after a fresh reset: id0 first, then id1; next pair id0 first again
    reset_pulse("reset2");
    expect_rsp(0, 16'd700, 1'b0, 1'b0);
    expect_rsp(1, 16'h0F00, 1'b0, 1'b0);
    raise(0, 16'd1000, 16'd300, OP_SUB);
    raise(1, 16'hFF00, 16'h0FF0, OP_AND);
    drain(40);
    expect_rsp(0, 16'd21, 1'b0, 1'b0);
    expect_rsp(1, 16'd0, 1'b1, 1'b0);
    raise(0, 16'd3, 16'd7, OP_MUL);
    raise(1, 16'd5, 16'd5, OP_SUB);
    drain(40);

    // response backpressure with a competing request waiting
    rsp_ready = 1'b0;
    expect_rsp(0, 16'd20000, 1'b0, 1'b0);
    expect_rsp(1, 16'd3, 1'b0, 1'b0);
    raise(0, 16'd100, 16'd200, OP_MUL);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
      tick();
    end
    check_val("bp_rsp_seen", 64'(rsp_valid), 64'd1);
    tick();
    raise(1, 16'd1, 16'd2, OP_ADD);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check_val("bp_rsp_data", 64'(rsp_data), 64'd20000);
      check_val("bp_no_ready", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_val("bp_hs_no_ready", 64'(req_ready), 64'd0);
    tick();
    @(negedge clk);
    check_val("bp_next_grant", 64'(req_ready), 64'b10);
    tick();
    drain(30);

    // back-to-back on req1: enable never drops, next grant one cycle after handshake
    expect_rsp(1, 16'd8000, 1'b0, 1'b0);
    raise(1, 16'd5000, 16'd3000, OP_ADD);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[1]) break;
      tick();
    end
    check_val("b2b_first_grant", 64'(req_ready), 64'b10);
    tick();
    expect_rsp(1, 16'd6000, 1'b0, 1'b0);
    raise(1, 16'd8000, 16'd2000, OP_SUB);
    hs = 0;
    g  = -100;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_val("b2b_enable", 64'(alu_enable), 64'd1);
      if (rsp_valid && rsp_ready) hs = cyc;
      if (req_ready[1]) begin
        g = cyc;
        break;
      end
      tick();
    end
    check_val("b2b_gap", 64'(g - hs), 64'd1);
    tick();
    drain(30);

    // wrap-around boundary: zero and carry flags pass through
    expect_rsp(0, 16'd0, 1'b1, 1'b1);
    raise(0, 16'hFFFF, 16'h0001, OP_ADD);
    drain(30);

    // reset mid-WAIT drops the transaction silently
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
      tick();
    end
    check_val("s6_asleep", 64'(busy), 64'd0);
    tick();
    raise(0, 16'd7, 16'd8, OP_ADD);
    tick();
    tick();
    tick();
    @(negedge clk);
    check_val("s6_in_wait_en", 64'(alu_enable), 64'd1);
    check_val("s6_in_wait_rspv", 64'(rsp_valid), 64'd0);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check_reset_outputs("s6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("s6_no_stale_rsp", 64'({rsp_valid, busy}), 64'd0);
    end
    @(posedge clk);
    #1;
    scen_wake(16'd1000, 16'd500, 16'd1500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
